// File: rtl/demux_reg_n_pkg.sv
// Shared defaults and types for the registered demultiplexer.
package demux_pkg;

    // Default data width and channel count.
    localparam int unsigned W_DEFAULT    = 8;
    localparam int unsigned N_DEFAULT    = 8;

    // Dropped-transfer counter width and saturation value.
    localparam int unsigned ERRO_CNT_W   = 8;
    localparam int unsigned ERRO_CNT_MAX = 255;

    // Holding-slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_reg_n_slot.sv
// One-entry holding register with valid/ready handshake for a single channel.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid,
    input  logic         ready,
    output logic         free
);

    slot_state_t state;

    // Occupancy FSM and data register; a load in the same cycle as a drain keeps the slot full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            q     <= '0;
        end else begin
            if (load) begin
                state <= SLOT_FULL;
                q     <= d;
            end else if (state == SLOT_FULL && ready) begin
                state <= SLOT_EMPTY;
            end
        end
    end

    assign valid = (state == SLOT_FULL);
    assign free  = !valid || ready;

endmodule

// File: rtl/demux_reg_n.sv
// Registered N-way demultiplexer with per-channel holding slots, broadcast and
// out-of-range drop reporting.
module demux_reg_n
    import demux_pkg::*;
#(
    parameter int unsigned W  = W_DEFAULT,
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          dados,
    input  logic [AW-1:0]         endereco,
    input  logic                  difusao,
    output logic [N*W-1:0]        out_dados,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic                  erro,
    output logic [ERRO_CNT_W-1:0] erro_cnt
);

    logic [N-1:0] sel;
    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         in_range;
    logic         accept;

    assign in_range = ({1'b0, endereco} < (AW+1)'(N));

    // One-hot decode of the destination; all zero when the address is out of range.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel[i] = (endereco == AW'(i));
        end
    end

    // Input readiness: broadcast needs every slot free, unicast only its own; bad addresses are swallowed.
    always_comb begin
        in_ready = 1'b1;
        if (difusao) begin
            in_ready = &free;
        end else if (in_range) begin
            in_ready = |(sel & free);
        end
    end

    assign accept = in_valid && in_ready;

    // Per-slot load strobes.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < N; i++) begin
            load[i] = accept && (difusao || sel[i]);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[g]),
            .d     (dados),
            .q     (out_dados[g*W +: W]),
            .valid (out_valid[g]),
            .ready (out_ready[g]),
            .free  (free[g])
        );
    end

    // Drop pulse and saturating drop counter for accepted out-of-range unicasts.
    always_ff @(posedge clk) begin
        if (reset) begin
            erro     <= 1'b0;
            erro_cnt <= '0;
        end else begin
            erro <= accept && !difusao && !in_range;
            if (accept && !difusao && !in_range &&
                erro_cnt != ERRO_CNT_W'(ERRO_CNT_MAX)) begin
                erro_cnt <= erro_cnt + 1'b1;
            end
        end
    end

endmodule
